// File: rtl/raw_bayer_capture.sv
// Sensor front end: registers the parallel camera bus, frames it into a raw Bayer
// pixel stream with X/Y coordinates, and measures/counts completed frames.
module raw_bayer_capture #(
  parameter int VIDEO_W = 800,
  parameter int VIDEO_H = 600
) (
  input  logic        BAYER_CLK,
  input  logic        reset,
  input  logic        CAM_FVAL,
  input  logic        CAM_LVAL,
  input  logic [9:0]  CAM_DATA,
  input  logic        ENABLE,
  output logic [11:0] BAYER_X,
  output logic [11:0] BAYER_Y,
  output logic [11:0] BAYER_DATA,
  output logic        BAYER_VALID,
  output logic [11:0] BAYER_WIDTH,
  output logic [11:0] BAYER_HEIGHT,
  output logic [19:0] FRAME_COUNT,
  output logic        OVERFLOW,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ARMED      = 2'd2,
    ACTIVE     = 2'd3
  } state_t;

  localparam logic [11:0] MAX_X = 12'(VIDEO_W);
  localparam logic [11:0] MAX_Y = 12'(VIDEO_H);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  state_t      state, state_nxt;
  logic        fval_r, lval_r, fval_d, lval_d;
  logic [9:0]  data_r;
  logic [11:0] x_cnt, y_cnt, len_cnt;
  logic        ovf;
  logic        p_valid, p_done;
  logic [11:0] p_x, p_y, p_data, p_width, p_height;

  logic        fval_rise, fval_fall, lval_fall;
  logic        frame_start, frame_end, in_frame;
  logic        pix_take, pix_fit, line_close, ovf_cur;
  logic [11:0] x_cur, y_cur, len_cur, y_close, len_close;

  assign fval_rise = fval_r & ~fval_d;
  assign fval_fall = ~fval_r & fval_d;
  assign lval_fall = ~lval_r & lval_d;
  assign state_dbg = state;

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE:       if (ENABLE) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (!fval_r) state_nxt = ARMED;
      ARMED: begin
        if (fval_rise) begin
          frame_start = 1'b1;
          state_nxt   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (fval_fall) begin
          frame_end = 1'b1;
          state_nxt = ENABLE ? ARMED : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On the frame-start cycle the counters are treated as already cleared, so a
  // pixel arriving together with the FVAL rise is still captured at (0,0).
  always_comb begin
    in_frame   = (state == ACTIVE) || frame_start;
    x_cur      = frame_start ? 12'd0 : x_cnt;
    y_cur      = frame_start ? 12'd0 : y_cnt;
    len_cur    = frame_start ? 12'd0 : len_cnt;
    ovf_cur    = frame_start ? 1'b0 : ovf;
    pix_take   = in_frame && fval_r && lval_r;
    pix_fit    = (x_cur < MAX_X) && (y_cur < MAX_Y);
    line_close = (state == ACTIVE) && lval_fall && (x_cnt != 12'd0);
    y_close    = line_close ? sat_inc(y_cur) : y_cur;
    len_close  = (line_close && (x_cur > len_cur)) ? x_cur : len_cur;
  end

  always_ff @(posedge BAYER_CLK or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      fval_r <= 1'b0;
      lval_r <= 1'b0;
      data_r <= 10'd0;
      fval_d <= 1'b0;
      lval_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      fval_r <= CAM_FVAL;
      lval_r <= CAM_LVAL;
      data_r <= CAM_DATA;
      fval_d <= fval_r;
      lval_d <= lval_r;
    end
  end

  // Counting stage, then an output stage that holds X/Y/DATA between pixels.
  always_ff @(posedge BAYER_CLK or posedge reset) begin
    if (reset) begin
      x_cnt        <= 12'd0;
      y_cnt        <= 12'd0;
      len_cnt      <= 12'd0;
      ovf          <= 1'b0;
      p_valid      <= 1'b0;
      p_done       <= 1'b0;
      p_x          <= 12'd0;
      p_y          <= 12'd0;
      p_data       <= 12'd0;
      p_width      <= 12'd0;
      p_height     <= 12'd0;
      BAYER_X      <= 12'd0;
      BAYER_Y      <= 12'd0;
      BAYER_DATA   <= 12'd0;
      BAYER_VALID  <= 1'b0;
      BAYER_WIDTH  <= 12'd0;
      BAYER_HEIGHT <= 12'd0;
      FRAME_COUNT  <= 20'd0;
      OVERFLOW     <= 1'b0;
    end else begin
      p_valid <= pix_take && pix_fit;
      p_done  <= frame_end;
      if (pix_take) begin
        p_x    <= x_cur;
        p_y    <= y_cur;
        p_data <= {data_r, data_r[9:8]};
      end
      if (in_frame) begin
        x_cnt   <= pix_take ? sat_inc(x_cur) : (lval_fall ? 12'd0 : x_cur);
        y_cnt   <= y_close;
        len_cnt <= len_close;
        ovf     <= ovf_cur | (pix_take & ~pix_fit);
      end
      if (frame_end) begin
        p_width  <= len_close;
        p_height <= y_close;
      end

      BAYER_VALID <= p_valid;
      OVERFLOW    <= ovf;
      if (p_valid) begin
        BAYER_X    <= p_x;
        BAYER_Y    <= p_y;
        BAYER_DATA <= p_data;
      end
      if (p_done) begin
        BAYER_WIDTH  <= p_width;
        BAYER_HEIGHT <= p_height;
        FRAME_COUNT  <= FRAME_COUNT + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_raw_bayer_capture.sv
// Bench for raw_bayer_capture: drives sensor frames and checks the pixel stream
// against a queue of expected pixels, plus frame size/count results.
module tb_raw_bayer_capture;
  localparam int VW = 8;
  localparam int VH = 6;
  localparam int W  = 68;

  logic        BAYER_CLK = 1'b0;
  logic        reset = 1'b1;
  logic        CAM_FVAL = 1'b0;
  logic        CAM_LVAL = 1'b0;
  logic [9:0]  CAM_DATA = 10'd0;
  logic        ENABLE = 1'b0;
  logic [11:0] BAYER_X, BAYER_Y, BAYER_DATA, BAYER_WIDTH, BAYER_HEIGHT;
  logic        BAYER_VALID, OVERFLOW;
  logic [19:0] FRAME_COUNT;
  logic [1:0]  state_dbg;

  raw_bayer_capture #(.VIDEO_W(VW), .VIDEO_H(VH)) dut (
    .BAYER_CLK   (BAYER_CLK),
    .reset       (reset),
    .CAM_FVAL    (CAM_FVAL),
    .CAM_LVAL    (CAM_LVAL),
    .CAM_DATA    (CAM_DATA),
    .ENABLE      (ENABLE),
    .BAYER_X     (BAYER_X),
    .BAYER_Y     (BAYER_Y),
    .BAYER_DATA  (BAYER_DATA),
    .BAYER_VALID (BAYER_VALID),
    .BAYER_WIDTH (BAYER_WIDTH),
    .BAYER_HEIGHT(BAYER_HEIGHT),
    .FRAME_COUNT (FRAME_COUNT),
    .OVERFLOW    (OVERFLOW),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 BAYER_CLK = ~BAYER_CLK;

  int cyc = 0;
  always @(posedge BAYER_CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // scoreboard: {stamp[31:0], x[11:0], y[11:0], data[11:0]}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int n_tests = 0;
  int n_fail  = 0;
  int last_fall_cyc = 0;
  int pix_k = 0;
  bit use_tab = 1'b0;
  logic [9:0] tab [3];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] expand_model(input logic [9:0] d);
    logic [11:0] v;
    v = {2'b00, d};
    return (v << 2) | (v >> 8);
  endfunction

  always @(posedge BAYER_CLK) begin
    #1;
    if (!reset && BAYER_VALID) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(BAYER_X), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("pix_x",    32'(BAYER_X),    32'(mon_e[35:24]));
        check("pix_y",    32'(BAYER_Y),    32'(mon_e[23:12]));
        check("pix_data", 32'(BAYER_DATA), 32'(mon_e[11:0]));
        check("pix_lat",  32'(cyc),        mon_e[67:36]);
      end
    end
  end

  // driver tasks
  task automatic step(input logic f, input logic l, input logic [9:0] d);
    @(negedge BAYER_CLK);
    CAM_FVAL = f;
    CAM_LVAL = l;
    CAM_DATA = d;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_x"},     32'(BAYER_X),      32'd0);
    check({tag, "_y"},     32'(BAYER_Y),      32'd0);
    check({tag, "_data"},  32'(BAYER_DATA),   32'd0);
    check({tag, "_valid"}, 32'(BAYER_VALID),  32'd0);
    check({tag, "_width"}, 32'(BAYER_WIDTH),  32'd0);
    check({tag, "_height"},32'(BAYER_HEIGHT), 32'd0);
    check({tag, "_fc"},    32'(FRAME_COUNT),  32'd0);
    check({tag, "_ovf"},   32'(OVERFLOW),     32'd0);
    check({tag, "_state"}, 32'(state_dbg),    32'd0);
  endtask

  task automatic do_reset();
    @(negedge BAYER_CLK);
    CAM_FVAL = 1'b0;
    CAM_LVAL = 1'b0;
    CAM_DATA = 10'd0;
    reset = 1'b1;
    exp_q.delete();
    pix_k = 0;
    repeat (3) @(negedge BAYER_CLK);
    check_outputs_zero("rst");
    reset = 1'b0;
  endtask

  // One frame: FVAL rise, h lines of w pixels with 2-cycle LVAL gaps, FVAL fall.
  task automatic send_frame(input int w, input int h, input bit cap, input bit simul,
                            input int en_line, input logic en_val, input int rst_line);
    bit cap_l;
    logic [9:0] d;
    cap_l = cap;
    step(1'b1, 1'b0, 10'd0);
    for (int y = 0; y < h; y++) begin
      if (y == en_line) ENABLE = en_val;
      if (rst_line >= 0 && y == rst_line + 1) reset = 1'b0;
      for (int x = 0; x < w; x++) begin
        d = use_tab ? tab[pix_k % 3] : 10'(pix_k + 1);
        pix_k++;
        if (y == rst_line && x == 2) cap_l = 1'b0;
        step(1'b1, 1'b1, d);
        if (cap_l && x < VW && y < VH)
          exp_q.push_back({32'(cyc + 3), 12'(x), 12'(y), expand_model(d)});
        if (y == rst_line && x == 2) begin
          #2;
          reset = 1'b1;
          exp_q.delete();
          #1;
          check_outputs_zero("async_rst");
        end
      end
      if (y == h - 1 && simul) begin
        step(1'b0, 1'b0, 10'd0);
      end else begin
        step(1'b1, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd0);
        if (y == h - 1) step(1'b0, 1'b0, 10'd0);
      end
    end
    last_fall_cyc = cyc;
  endtask

  task automatic wait_done(input logic [19:0] exp_fc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge BAYER_CLK);
      #1;
      if (FRAME_COUNT == exp_fc) begin
        seen = 1'b1;
        check("done_lat", 32'(cyc), 32'(last_fall_cyc + 3));
      end
    end
    if (!seen) check("done_timeout", 32'(FRAME_COUNT), 32'(exp_fc));
  endtask

  task automatic check_frame(input int w, input int h, input logic ovf);
    check("width",    32'(BAYER_WIDTH),  32'(w));
    check("height",   32'(BAYER_HEIGHT), 32'(h));
    check("overflow", 32'(OVERFLOW),     32'(ovf));
    check("leftover", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    tab[0] = 10'h3FF;
    tab[1] = 10'h200;
    tab[2] = 10'h000;

    // basic 4x3 frame
    ENABLE = 1'b1;
    do_reset();
    idle(3);
    send_frame(4, 3, 1'b1, 1'b0, -1, 1'b1, -1);
    wait_done(20'd1);
    check_frame(4, 3, 1'b0);

    // enable raised mid-frame: frame A ignored, frame B captured
    ENABLE = 1'b0;
    do_reset();
    idle(2);
    send_frame(4, 3, 1'b0, 1'b0, 1, 1'b1, -1);
    idle(6);
    check("midenable_fc_a", 32'(FRAME_COUNT), 32'd0);
    send_frame(4, 3, 1'b1, 1'b0, -1, 1'b1, -1);
    wait_done(20'd1);
    check_frame(4, 3, 1'b0);

    // oversize 10x7 frame, then overflow clears on next frame
    ENABLE = 1'b1;
    do_reset();
    idle(3);
    send_frame(10, 7, 1'b1, 1'b0, -1, 1'b1, -1);
    wait_done(20'd1);
    check_frame(10, 7, 1'b1);
    idle(3);
    check("ovf_hold", 32'(OVERFLOW), 32'd1);
    send_frame(4, 3, 1'b1, 1'b0, -1, 1'b1, -1);
    wait_done(20'd2);
    check_frame(4, 3, 1'b0);

    // data expansion with FVAL/LVAL falling together
    use_tab = 1'b1;
    do_reset();
    idle(3);
    send_frame(3, 2, 1'b1, 1'b1, -1, 1'b1, -1);
    wait_done(20'd1);
    check_frame(3, 2, 1'b0);
    idle(4);
    check("simul_fc_once", 32'(FRAME_COUNT), 32'd1);
    use_tab = 1'b0;

    // enable dropped mid-frame: frame completes, next frame ignored
    ENABLE = 1'b1;
    do_reset();
    idle(3);
    send_frame(4, 3, 1'b1, 1'b0, 1, 1'b0, -1);
    wait_done(20'd1);
    check_frame(4, 3, 1'b0);
    check("disable_idle", 32'(state_dbg), 32'd0);
    idle(3);
    send_frame(4, 3, 1'b0, 1'b0, -1, 1'b0, -1);
    idle(8);
    check("disable_fc", 32'(FRAME_COUNT), 32'd1);

    // asynchronous reset at pixel (2,1), released while FVAL high
    ENABLE = 1'b1;
    do_reset();
    idle(3);
    send_frame(4, 3, 1'b1, 1'b0, -1, 1'b1, 1);
    idle(8);
    check("rst_frame_fc", 32'(FRAME_COUNT), 32'd0);
    send_frame(4, 3, 1'b1, 1'b0, -1, 1'b1, -1);
    wait_done(20'd1);
    check_frame(4, 3, 1'b0);

    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/raw_bayer_capture.md
# raw_bayer_capture

Front-end capture stage for the D8M camera path. It samples the sensor's parallel output (frame-valid, line-valid, 10-bit raw data) on the pixel clock and produces the raw Bayer pixel stream consumed by the Bayer-to-RGB demosaic stage. Each accepted pixel carries X/Y coordinates, a VALID strobe and 12-bit data. The block also measures the size of every completed frame and counts frames.

## Interface
- VIDEO_W, 800, maximum accepted pixels per line; X range 0..VIDEO_W-1
- VIDEO_H, 600, maximum accepted lines per frame; Y range 0..VIDEO_H-1
- BAYER_CLK  in  1  sensor pixel clock; the only clock
- reset  in  1  asynchronous, active-high reset
- CAM_FVAL  in  1  sensor frame valid
- CAM_LVAL  in  1  sensor line valid
- CAM_DATA  in  10  raw sensor pixel
- ENABLE  in  1  capture enable; honoured only at frame boundaries
- BAYER_X  out  12  column of current pixel
- BAYER_Y  out  12  row of current pixel
- BAYER_DATA  out  12  expanded pixel data
- BAYER_VALID  out  1  pixel strobe, one cycle per accepted pixel
- BAYER_WIDTH  out  12  longest line of last completed frame, in pixels
- BAYER_HEIGHT  out  12  line count of last completed frame
- FRAME_COUNT  out  20  completed captured frames, wraps modulo 2^20
- OVERFLOW  out  1  sticky: current or last frame exceeded VIDEO_W or VIDEO_H

## Operation
- Stage 1 registers CAM_FVAL, CAM_LVAL and CAM_DATA. All control decisions use these registered copies and their one-cycle-delayed versions (edge detect).
- States:
  - IDLE: output nothing. Go to WAIT_FRAME when ENABLE=1.
  - WAIT_FRAME: wait until the registered FVAL is 0, then go to ARMED. This prevents capture of a partial frame.
  - ARMED: on the FVAL rising edge, clear the X, Y, line-length and OVERFLOW counters/flags and go to ACTIVE.
  - ACTIVE: capture pixels. On the FVAL falling edge, finish the frame, then go to ARMED if ENABLE=1, else IDLE.
- A pixel is accepted in ACTIVE when registered FVAL=1 and registered LVAL=1.
  - If x_cnt < VIDEO_W and y_cnt < VIDEO_H: emit BAYER_VALID=1, X=x_cnt, Y=y_cnt.
  - Otherwise drop the pixel (VALID=0) and set OVERFLOW.
  - x_cnt increments on every LVAL-high cycle and saturates at 4095.
- LVAL falling edge inside a frame:
  - If x_cnt>0: y_cnt increments (saturating at 4095) and max_len = max(max_len, x_cnt).
  - x_cnt clears to 0.
- FVAL falling edge in ACTIVE:
  - BAYER_WIDTH <= max_len; BAYER_HEIGHT <= y_cnt; FRAME_COUNT increments.
  - If LVAL falls in the same cycle, the line is closed first and its contribution is included in WIDTH/HEIGHT.
- OVERFLOW clears only at the FVAL rising edge in ARMED, and holds through IDLE.
- LVAL activity while FVAL=0 is ignored.
- Data expansion: BAYER_DATA = {CAM_DATA, CAM_DATA[9:8]} (MSB replication). 0 maps to 0; 3FF maps to FFF.
- While VALID=0, BAYER_X/Y/DATA hold their last values.
- ENABLE deassertion mid-frame does not truncate the frame. ENABLE assertion mid-frame takes effect at the next full frame.

## Timing
- Reset: all outputs 0, state IDLE, all internal counters 0, stage-1 registers 0.
- Release of reset while the sensor is mid-frame: the block passes through WAIT_FRAME, so no partial frame is emitted.
- Latency: a pixel sampled at rising edge t appears on BAYER_X/Y/DATA/VALID after edge t+2. The interval is fixed, with no bubbles or back-pressure.
- Pixel throughput: one pixel per clock. Consecutive pixels in a line have consecutive X.
- Frame completion: BAYER_WIDTH, BAYER_HEIGHT and FRAME_COUNT update together, 2 cycles after the CAM_FVAL falling edge is sampled. They are stable for a full frame.
- The last pixel of a frame (VALID) always precedes or coincides with the frame-complete update; it never follows it.
- Minimum gaps:
  - FVAL low: 1 cycle between frames.
  - LVAL low: 1 cycle between lines.
  - Shorter gaps are merged: no edge is seen.

## Test plan
- Basic frame:
  - Setup: VIDEO_W=8, VIDEO_H=6, ENABLE=1 before the frame. Stimulus: one 4×3 frame with CAM_DATA = 10'h001, 10'h002, … and LVAL gaps of 2 cycles.
  - Response: 12 VALID pulses, X 0..3 repeated for Y 0..2. DATA is 12'h004, 12'h008, …, each appearing 2 cycles after input. Then WIDTH=4, HEIGHT=3, FRAME_COUNT=1, OVERFLOW=0.
- Mid-frame enable:
  - Stimulus: ENABLE raised during line 1 of frame A; full frame B follows.
  - Response: no VALID during frame A; frame B captured from X=0, Y=0; FRAME_COUNT=1 after B.
- Oversize frame:
  - Stimulus: VIDEO_W=8, VIDEO_H=6; a frame of 7 lines of 10 pixels.
  - Response: X 0..7 valid on lines 0..5; pixels 8–9 and all of line 6 dropped. OVERFLOW=1, WIDTH=10, HEIGHT=7.
  - Follow-up: OVERFLOW clears at the next frame's FVAL rise.
- Data expansion and simultaneous edges:
  - Stimulus: CAM_DATA 3FF, 200, 000; FVAL and LVAL fall in the same cycle.
  - Response: DATA FFF, 802, 000. The last line is counted (HEIGHT includes it) and FRAME_COUNT increments once.
- Mid-frame disable:
  - Stimulus: ENABLE dropped at line 1 of a 4×3 frame.
  - Response: the whole frame is emitted (12 pixels), FRAME_COUNT increments, the state goes to IDLE, and the next frame produces no VALID.
- Reset mid-frame:
  - Stimulus: reset asserted at pixel (2,1) and released while FVAL is still high.
  - Response: all outputs 0 immediately (asynchronous). The remainder of that frame is ignored; the next frame is captured normally with FRAME_COUNT=1.
